// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART register bridge:
// command/response bytes and the control FSM state encoding.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_SEND
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Bridge signal bundle: UART rx/tx FIFO side plus register bus.
// master = bridge, slave = FIFOs/register file environment.
interface uart_reg_bridge_if;

    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;

    modport master (
        input  rx_empty,
        input  r_data,
        input  tx_full,
        input  bus_rdata,
        output rd_uart,
        output w_data,
        output wr_uart,
        output bus_addr,
        output bus_wdata,
        output bus_we,
        output bus_re
    );

    modport slave (
        output rx_empty,
        output r_data,
        output tx_full,
        output bus_rdata,
        input  rd_uart,
        input  w_data,
        input  wr_uart,
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        input  bus_re
    );

endinterface

// File: rtl/uart_bridge_timer.sv
// Inter-byte timeout counter: clear/enable with terminal count.
// Ports: clk_i, rst_ni (async low), clr_i, en_i -> tc_o at TIMEOUT-1.
module uart_bridge_timer #(
    parameter int unsigned TIMEOUT = 500000,
    parameter int unsigned TO_BIT  = 19
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TO_BIT-1:0] LAST = TO_BIT'(TIMEOUT - 1);

    logic [TO_BIT-1:0] cnt_q;
    logic [TO_BIT-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // Holds at terminal count so a long stall cannot wrap around.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + TO_BIT'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command bridge: 'W' A D writes a register (reply 'K'),
// 'R' A reads one (reply data), anything else replies '?'.
// Ports: clk, reset (async low), bus (uart_reg_bridge_if.master).
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 500000,
    parameter int unsigned TO_BIT  = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_reg_bridge_if.master     bus
);

    state_e     state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] resp_q, resp_d;
    logic       wr_turn_q, wr_turn_d;
    logic       run_q;

    logic       rd;
    logic       we;
    logic       re;
    logic       wr;
    logic       take;
    logic       in_get;
    logic       tmr_clr;
    logic       tmr_tc;

    // run_q keeps every strobe quiet for the first edge after reset
    // release, even with a byte already waiting in the rx FIFO.
    assign take   = run_q && !bus.rx_empty;
    assign in_get = (state_q == ST_GET_ADDR) ||
                    (state_q == ST_GET_DATA);

    assign tmr_clr = !in_get || rd;

    uart_bridge_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_BIT  (TO_BIT)
    ) u_timer (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (tmr_clr),
        .en_i   (in_get),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        wr_turn_d = wr_turn_q;
        rd        = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        wr        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    rd = 1'b1;
                    if (is_opcode(bus.r_data)) begin
                        is_wr_d = (bus.r_data == OP_WR);
                        state_d = ST_GET_ADDR;
                    end else begin
                        resp_d  = RSP_ERR;
                        state_d = ST_SEND;
                    end
                end
            end

            // A byte arriving on the terminal-count cycle still wins.
            ST_GET_ADDR: begin
                if (take) begin
                    rd      = 1'b1;
                    addr_d  = bus.r_data;
                    state_d = is_wr_q ? ST_GET_DATA : ST_BUS_RD;
                end else if (tmr_tc) begin
                    state_d = ST_IDLE;
                end
            end

            ST_GET_DATA: begin
                if (take) begin
                    rd      = 1'b1;
                    wdata_d = bus.r_data;
                    state_d = ST_BUS_WR;
                end else if (tmr_tc) begin
                    state_d = ST_IDLE;
                end
            end

            // Write strobe, then one turnaround cycle so a write reply
            // leaves two cycles after its strobe, like a read reply.
            ST_BUS_WR: begin
                if (!wr_turn_q) begin
                    we        = 1'b1;
                    wr_turn_d = 1'b1;
                end else begin
                    wr_turn_d = 1'b0;
                    resp_d    = RSP_OK;
                    state_d   = ST_SEND;
                end
            end

            ST_BUS_RD: begin
                re      = 1'b1;
                state_d = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                resp_d  = bus.bus_rdata;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (!bus.tx_full) begin
                    wr      = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            resp_q    <= 8'h00;
            wr_turn_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            resp_q    <= resp_d;
            wr_turn_q <= wr_turn_d;
            run_q     <= 1'b1;
        end
    end

    assign bus.rd_uart   = rd;
    assign bus.wr_uart   = wr;
    assign bus.w_data    = resp_q;
    assign bus.bus_we    = we;
    assign bus.bus_re    = re;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomised self-checking bench for uart_reg_bridge with a
// command-level reference model of the register file and replies.
module tb_uart_reg_bridge;

    localparam int TO = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_reg_bridge_if bif ();

    uart_reg_bridge #(
        .TIMEOUT (TO),
        .TO_BIT  (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  smem[256];
    logic [7:0]  mmem[256];
    logic [7:0]  obs_tx[$];
    int          obs_txc[$];
    logic [15:0] obs_wr[$];
    logic [7:0]  obs_rd[$];

    int cyc = 0;
    int pop_cyc = 0;
    int we_cyc = 0;
    int re_cyc = 0;
    int n_pop = 0;
    bit tx_force = 1'b0;
    bit tx_rand = 1'b0;
    bit re_pend = 1'b0;
    logic [7:0] re_addr = 8'h00;

    // Environment: rx FIFO, tx FIFO sink and register file.
    // Inputs change 1 time unit after posedge; strobes sampled at negedge.
    initial begin
        bif.rx_empty  = 1'b1;
        bif.r_data    = 8'h00;
        bif.tx_full   = 1'b0;
        bif.bus_rdata = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bif.rx_empty  = (rxq.size() == 0);
            bif.r_data    = (rxq.size() != 0) ? rxq[0] : 8'h00;
            bif.tx_full   = tx_rand ? ($urandom_range(0, 2) == 0) : tx_force;
            bif.bus_rdata = re_pend ? smem[re_addr] : 8'($urandom);
            re_pend = 1'b0;
            @(negedge clk);
            if (bif.rd_uart) begin
                checks++;
                if (bif.rx_empty !== 1'b0) begin
                    errors++;
                    $display("FAIL pop_when_empty rx_empty=%b required 0", bif.rx_empty);
                end else begin
                    void'(rxq.pop_front());
                end
                pop_cyc = cyc;
                n_pop++;
            end
            if (bif.wr_uart) begin
                checks++;
                if (bif.tx_full !== 1'b0) begin
                    errors++;
                    $display("FAIL push_when_full tx_full=%b required 0", bif.tx_full);
                end
                obs_tx.push_back(bif.w_data);
                obs_txc.push_back(cyc);
            end
            if (bif.bus_we) begin
                obs_wr.push_back({bif.bus_addr, bif.bus_wdata});
                smem[bif.bus_addr] = bif.bus_wdata;
                we_cyc = cyc;
            end
            if (bif.bus_re) begin
                obs_rd.push_back(bif.bus_addr);
                re_pend = 1'b1;
                re_addr = bif.bus_addr;
                re_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        obs_tx.delete();
        obs_txc.delete();
        obs_wr.delete();
        obs_rd.delete();
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        rxq.push_back(a);
        if (n > 1) rxq.push_back(b);
        if (n > 2) rxq.push_back(c);
    endtask

    task automatic wait_tx(input int n, input int budget, input string nm);
        int k = 0;
        while (obs_tx.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (obs_tx.size() < n) begin
            errors++;
            $display("FAIL %s_wait replies=%0d required %0d", nm, obs_tx.size(), n);
        end
    endtask

    task automatic wait_pops(input int target, input int budget, input string nm);
        int k = 0;
        while (n_pop < target && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (n_pop < target) begin
            errors++;
            $display("FAIL %s_pops pops=%0d required %0d", nm, n_pop, target);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b required 0000",
                     {bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re});
        end
        checks++;
        if ({bif.w_data, bif.bus_addr, bif.bus_wdata} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_data got %h required 000000",
                     {bif.w_data, bif.bus_addr, bif.bus_wdata});
        end
        idle(3);
        @(posedge clk);
        #3 reset = 1'b1;
        idle(3);
    endtask

    task automatic test_write();
        clear_obs();
        push3(8'h57, 8'h10, 8'hA5, 3);
        mmem[8'h10] = 8'hA5;
        wait_tx(1, 100, "write");
        idle(5);
        checks++;
        if (obs_wr.size() != 1 || obs_wr[0] !== 16'h10A5) begin
            errors++;
            $display("FAIL write_bus n=%0d got %h required 1 x 10A5", obs_wr.size(), obs_wr[0]);
        end
        checks++;
        if (obs_tx.size() != 1 || obs_tx[0] !== 8'h4B) begin
            errors++;
            $display("FAIL write_reply n=%0d got %h required 1 x 4B", obs_tx.size(), obs_tx[0]);
        end
        checks++;
        if (we_cyc != pop_cyc + 1) begin
            errors++;
            $display("FAIL write_we_latency got %0d required %0d", we_cyc - pop_cyc, 1);
        end
        checks++;
        if (obs_txc[0] != we_cyc + 2) begin
            errors++;
            $display("FAIL write_reply_latency got %0d required %0d", obs_txc[0] - we_cyc, 2);
        end
        checks++;
        if ({bif.bus_addr, bif.bus_wdata} !== 16'h10A5) begin
            errors++;
            $display("FAIL write_hold got %h required 10A5", {bif.bus_addr, bif.bus_wdata});
        end
    endtask

    task automatic test_read();
        clear_obs();
        smem[8'h22] = 8'h3C;
        mmem[8'h22] = 8'h3C;
        push3(8'h52, 8'h22, 8'h00, 2);
        wait_tx(1, 100, "read");
        idle(5);
        checks++;
        if (obs_rd.size() != 1 || obs_rd[0] !== 8'h22 || obs_wr.size() != 0) begin
            errors++;
            $display("FAIL read_bus n=%0d addr=%h writes=%0d required 1 x 22, 0 writes",
                     obs_rd.size(), obs_rd[0], obs_wr.size());
        end
        checks++;
        if (obs_tx.size() != 1 || obs_tx[0] !== mmem[8'h22]) begin
            errors++;
            $display("FAIL read_reply n=%0d got %h required 1 x %h",
                     obs_tx.size(), obs_tx[0], mmem[8'h22]);
        end
        checks++;
        if (obs_txc[0] != re_cyc + 2) begin
            errors++;
            $display("FAIL read_latency got %0d required %0d", obs_txc[0] - re_cyc, 2);
        end
    endtask

    task automatic test_bad_opcode();
        clear_obs();
        push3(8'h41, 8'h00, 8'h00, 1);
        wait_tx(1, 50, "bad");
        idle(4);
        checks++;
        if (obs_tx.size() != 1 || obs_tx[0] !== 8'h3F || obs_wr.size() + obs_rd.size() != 0) begin
            errors++;
            $display("FAIL bad_reply n=%0d got %h bus=%0d required 1 x 3F, 0 bus",
                     obs_tx.size(), obs_tx[0], obs_wr.size() + obs_rd.size());
        end
        clear_obs();
        push3(8'h57, 8'h33, 8'h5A, 3);
        mmem[8'h33] = 8'h5A;
        wait_tx(1, 100, "bad_then_write");
        idle(4);
        checks++;
        if (obs_wr.size() != 1 || obs_wr[0] !== 16'h335A || obs_tx[0] !== 8'h4B) begin
            errors++;
            $display("FAIL bad_then_write n=%0d wr=%h tx=%h required 1 x 335A, 4B",
                     obs_wr.size(), obs_wr[0], obs_tx[0]);
        end
    endtask

    task automatic test_timeout();
        int p;
        clear_obs();
        push3(8'h57, 8'h10, 8'h00, 2);
        wait_pops(n_pop + 2, 50, "timeout");
        idle(TO + 5);
        checks++;
        if (obs_tx.size() != 0 || obs_wr.size() != 0) begin
            errors++;
            $display("FAIL timeout_silent tx=%0d wr=%0d required 0 0", obs_tx.size(), obs_wr.size());
        end
        push3(8'h52, 8'h10, 8'h00, 2);
        wait_tx(1, 100, "timeout_read");
        idle(4);
        checks++;
        if (obs_tx.size() != 1 || obs_tx[0] !== mmem[8'h10]) begin
            errors++;
            $display("FAIL timeout_read n=%0d got %h required 1 x %h",
                     obs_tx.size(), obs_tx[0], mmem[8'h10]);
        end

        // Data byte shows up on the very cycle the timeout fires: accepted.
        clear_obs();
        push3(8'h57, 8'h55, 8'h00, 2);
        wait_pops(n_pop + 2, 50, "edge_in");
        p = pop_cyc;
        while (cyc < p + TO - 1) tick();
        rxq.push_back(8'h77);
        mmem[8'h55] = 8'h77;
        wait_tx(1, 100, "edge_in");
        idle(4);
        checks++;
        if (obs_wr.size() != 1 || obs_wr[0] !== 16'h5577 || obs_tx[0] !== 8'h4B) begin
            errors++;
            $display("FAIL byte_wins n=%0d wr=%h tx=%h required 1 x 5577, 4B",
                     obs_wr.size(), obs_wr[0], obs_tx[0]);
        end

        // One cycle later: the command is gone and the byte is a new opcode.
        clear_obs();
        push3(8'h57, 8'h56, 8'h00, 2);
        wait_pops(n_pop + 2, 50, "edge_out");
        p = pop_cyc;
        while (cyc < p + TO) tick();
        rxq.push_back(8'h66);
        wait_tx(1, 100, "edge_out");
        idle(4);
        checks++;
        if (obs_wr.size() != 0 || obs_tx.size() != 1 || obs_tx[0] !== 8'h3F) begin
            errors++;
            $display("FAIL timeout_edge wr=%0d n=%0d tx=%h required 0, 1 x 3F",
                     obs_wr.size(), obs_tx.size(), obs_tx[0]);
        end
    endtask

    task automatic test_tx_full();
        int n0;
        int rel;
        clear_obs();
        tx_force = 1'b1;
        n0 = n_pop;
        push3(8'h52, 8'h22, 8'h41, 3);
        idle(56);
        checks++;
        if (obs_tx.size() != 0 || n_pop != n0 + 2 || rxq.size() != 1) begin
            errors++;
            $display("FAIL txfull_hold tx=%0d pops=%0d left=%0d required 0 %0d 1",
                     obs_tx.size(), n_pop - n0, rxq.size(), 2);
        end
        tx_force = 1'b0;
        rel = cyc + 1;
        wait_tx(2, 60, "txfull");
        idle(4);
        checks++;
        if (obs_tx.size() != 2 || obs_tx[0] !== mmem[8'h22] || obs_tx[1] !== 8'h3F) begin
            errors++;
            $display("FAIL txfull_release n=%0d got %h %h required 2 x %h 3F",
                     obs_tx.size(), obs_tx[0], obs_tx[1], mmem[8'h22]);
        end
        checks++;
        if (obs_txc[0] != rel) begin
            errors++;
            $display("FAIL txfull_first_push cycle=%0d required %0d", obs_txc[0], rel);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_tx[$];
        logic [15:0] exp_wr[$];
        logic [7:0]  exp_rd[$];
        logic [7:0]  a;
        logic [7:0]  d;
        logic [7:0]  b;
        int          kind;
        clear_obs();
        tx_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if (kind == 0) begin
                push3(8'h57, a, d, 3);
                mmem[a] = d;
                exp_wr.push_back({a, d});
                exp_tx.push_back(8'h4B);
            end else if (kind == 1) begin
                push3(8'h52, a, 8'h00, 2);
                exp_rd.push_back(a);
                exp_tx.push_back(mmem[a]);
            end else begin
                b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                push3(b, 8'h00, 8'h00, 1);
                exp_tx.push_back(8'h3F);
            end
        end
        wait_tx(exp_tx.size(), 3000, "b2b");
        tx_rand = 1'b0;
        idle(6);
        checks++;
        if (obs_tx.size() != exp_tx.size() || obs_wr.size() != exp_wr.size() ||
            obs_rd.size() != exp_rd.size()) begin
            errors++;
            $display("FAIL b2b_counts tx=%0d wr=%0d rd=%0d required %0d %0d %0d",
                     obs_tx.size(), obs_wr.size(), obs_rd.size(),
                     exp_tx.size(), exp_wr.size(), exp_rd.size());
        end
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
            checks++;
            if (obs_tx[i] !== exp_tx[i]) begin
                errors++;
                $display("FAIL b2b_reply[%0d] got %h required %h", i, obs_tx[i], exp_tx[i]);
            end
        end
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL b2b_write[%0d] got %h required %h", i, obs_wr[i], exp_wr[i]);
            end
        end
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
            checks++;
            if (obs_rd[i] !== exp_rd[i]) begin
                errors++;
                $display("FAIL b2b_read[%0d] got %h required %h", i, obs_rd[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        push3(8'h57, 8'h44, 8'h00, 2);
        wait_pops(n_pop + 2, 50, "rst_mid");
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re} !== 4'b0000 ||
            {bif.w_data, bif.bus_addr, bif.bus_wdata} !== 24'h000000) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b %h required 0000 000000",
                     {bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re},
                     {bif.w_data, bif.bus_addr, bif.bus_wdata});
        end
        rxq.push_back(8'h99);
        idle(4);
        @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_release_quiet got %b required 0000",
                     {bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re});
        end
        #1;
        wait_tx(1, 50, "rst_mid");
        idle(4);
        checks++;
        if (obs_wr.size() != 0 || obs_tx.size() != 1 || obs_tx[0] !== 8'h3F) begin
            errors++;
            $display("FAIL rst_mid_discard wr=%0d n=%0d tx=%h required 0, 1 x 3F",
                     obs_wr.size(), obs_tx.size(), obs_tx[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i] = 8'($urandom);
            mmem[i] = smem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_timeout();
        test_tx_full();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 500000, inter-byte timeout in clk cycles (>=2).
REQ-002 SHALL have parameter TO_BIT, default 19, width of the timeout counter (2^TO_BIT > TIMEOUT).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_empty  input  1  UART receive FIFO empty.
REQ-006 r_data  input  8  UART receive FIFO head byte, valid while rx_empty=0.
REQ-007 rd_uart  output  1  one-cycle pop of the receive FIFO.
REQ-008 tx_full  input  1  UART transmit FIFO full.
REQ-009 w_data  output  8  byte pushed to the transmit FIFO.
REQ-010 wr_uart  output  1  one-cycle push to the transmit FIFO.
REQ-011 bus_addr  output  8  register address.
REQ-012 bus_wdata  output  8  register write data.
REQ-013 bus_we  output  1  one-cycle register write strobe.
REQ-014 bus_re  output  1  one-cycle register read strobe.
REQ-015 bus_rdata  input  8  read data, valid exactly one cycle after bus_re.

Function
REQ-016 Command protocol: 'W'(0x57) A D -> write D to A, reply 'K'(0x4B); 'R'(0x52) A -> read A, reply the data byte; any other first byte -> reply '?'(0x3F).
REQ-017 States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND.
REQ-018 Byte consume: in IDLE/GET_ADDR/GET_DATA with rx_empty=0, SHALL sample r_data and assert rd_uart for exactly that one cycle; never assert rd_uart while rx_empty=1.
REQ-019 IDLE: 'W' or 'R' -> GET_ADDR and latch opcode; other byte -> SEND with '?'.
REQ-020 GET_ADDR: latch bus_addr; opcode W -> GET_DATA; opcode R -> BUS_RD.
REQ-021 GET_DATA: latch bus_wdata -> BUS_WR.
REQ-022 BUS_WR: bus_we=1 for one cycle, response 'K' -> SEND.
REQ-023 BUS_RD: bus_re=1 for one cycle -> RD_WAIT; RD_WAIT captures bus_rdata as response -> SEND.
REQ-024 SEND: while tx_full=1, hold response, wr_uart=0; first cycle with tx_full=0 assert wr_uart with w_data=response for one cycle -> IDLE.
REQ-025 Exactly one response byte per command; no bytes consumed during BUS_*, RD_WAIT, SEND.
REQ-026 Timeout: in GET_ADDR/GET_DATA, counter clears on state entry and on each consumed byte and increments otherwise; on reaching TIMEOUT-1 with rx_empty=1 SHALL return to IDLE, discard the partial command, send no reply, and not touch the bus.
REQ-027 Byte arrival and timeout in the same cycle: the byte wins.
REQ-028 Latency: bus_we asserts 1 cycle after the D byte pop; reply push (tx_full=0) 2 cycles after bus_we, or 2 cycles after bus_re for a read.
REQ-029 bus_addr/bus_wdata SHALL hold their last value outside strobes.

Reset
REQ-030 reset=0 SHALL force IDLE, counter 0, rd_uart/wr_uart/bus_we/bus_re=0, w_data/bus_addr/bus_wdata=0x00 immediately, regardless of clk.
REQ-031 Reset mid-command discards it; no strobe may assert in the first cycle after release.

Structure
REQ-032 Opcode/response constants (0x57, 0x52, 0x4B, 0x3F) and state encoding SHALL live in a shared package/include file uart_bridge_pkg.
REQ-033 One sub-module SHALL be used: uart_bridge_timer (clear/enable timeout counter with terminal-count output).

Verification
REQ-034 Push 0x57,0x10,0xA5 -> bus_we one cycle with bus_addr=0x10, bus_wdata=0xA5; w_data=0x4B pushed once.
REQ-035 Push 0x52,0x22, bus model returns 0x3C -> bus_re one cycle with bus_addr=0x22; w_data=0x3C pushed once.
REQ-036 Push 0x41 -> no bus strobe; 0x3F pushed; then a valid write command executes normally.
REQ-037 Push 0x57,0x10 then idle TIMEOUT cycles -> back to IDLE, no bus_we, no reply; next 0x52,0x10 replies correctly.
REQ-038 tx_full=1 held 50 cycles during reply -> wr_uart stays 0 and no bytes are consumed; releasing tx_full gives a single push.
REQ-039 reset=0 asserted in GET_DATA -> all outputs 0 asynchronously; the pending write never occurs after release.
